// File: rtl/sram_banked_1rw_ctrl_pkg.sv
// Shared types and width helpers for the banked 1RW SRAM controller.
// All widths are derived from the top-level parameters through these functions.
package sram_ctrl_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  function automatic int calc_mask_w(input int data_w);
    return data_w / 8;
  endfunction

  // A single bank needs no select bits at all.
  function automatic int calc_bsel(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 0;
  endfunction

  function automatic int calc_row_w(input int bank_words);
    return $clog2(bank_words);
  endfunction

  function automatic int calc_addr_w(input int num_banks, input int bank_words);
    return $clog2(num_banks * bank_words);
  endfunction

endpackage

// File: rtl/sram_banked_1rw_ctrl_if.sv
// Core-side request/response bus of the banked SRAM controller.
// The master is the core; the slave is the controller.
interface sram_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int MASK_W = 4,
  parameter int WORD_W = 33
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_wmask;
  logic              req_spare_wen;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wmask, req_spare_wen, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wmask, req_spare_wen, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );
endinterface

// File: rtl/sram_1rw_model.sv
// Behavioural model of one 1RW SRAM bank: active-low select/write, byte mask,
// optional spare column bit at the MSB, one-cycle read latency, dout holds last read.
module sram_1rw_model #(
  parameter int WORDS    = 1024,
  parameter int DATA_W   = 32,
  parameter int SPARE_EN = 1
) (
  input  logic                         clk0,
  input  logic                         csb0,
  input  logic                         web0,
  input  logic [DATA_W/8-1:0]          wmask0,
  input  logic                         spare_wen0,
  input  logic [$clog2(WORDS)-1:0]     addr0,
  input  logic [DATA_W+SPARE_EN-1:0]   din0,
  output logic [DATA_W+SPARE_EN-1:0]   dout0
);
  localparam int WORD_W = DATA_W + SPARE_EN;

  logic [WORD_W-1:0] mem [WORDS];

  // Like the hard macro, the array and output register carry no reset.
  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        for (int i = 0; i < DATA_W / 8; i++) begin
          if (wmask0[i]) begin
            mem[addr0][8*i +: 8] <= din0[8*i +: 8];
          end
        end
        if (SPARE_EN != 0 && spare_wen0) begin
          mem[addr0][WORD_W-1] <= din0[WORD_W-1];
        end
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end
endmodule

// File: rtl/sram_banked_1rw_ctrl.sv
// Multi-bank controller over 1RW SRAM banks: optional zero-init after reset,
// credit-gated request port and an in-order, back-pressurable read-response FIFO.
module sram_banked_1rw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_BANKS   = 4,
  parameter int BANK_WORDS  = 1024,
  parameter int SPARE_EN    = 1,
  parameter int RSP_DEPTH   = 2,
  parameter int INIT_ON_RST = 1
) (
  input  logic         clk0,
  input  logic         rst0,
  sram_ctrl_if.slave   bus
);
  localparam int MASK_W = calc_mask_w(DATA_W);
  localparam int BSEL   = calc_bsel(NUM_BANKS);
  localparam int ROW_W  = calc_row_w(BANK_WORDS);
  localparam int ADDR_W = calc_addr_w(NUM_BANKS, BANK_WORDS);
  localparam int WORD_W = DATA_W + SPARE_EN;
  localparam int BS_W   = (BSEL > 0) ? BSEL : 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1) + 1;
  localparam int PTR_W  = $clog2(RSP_DEPTH);

  state_t            state, state_next;
  logic [ROW_W-1:0]  row_cnt;
  logic              init_done_q;
  logic [BS_W-1:0]   req_bank, rd_bank;
  logic [ROW_W-1:0]  req_row;
  logic              fire, rd_fire, inflight, push, pop;
  logic [CNT_W-1:0]  occ, credit_used;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [WORD_W-1:0] fifo_mem [RSP_DEPTH];

  logic [NUM_BANKS-1:0] bank_csb;
  logic                 bank_web;
  logic [MASK_W-1:0]    bank_wmask;
  logic                 bank_spare_wen;
  logic [ROW_W-1:0]     bank_addr;
  logic [WORD_W-1:0]    bank_din;
  logic [WORD_W-1:0]    bank_dout [NUM_BANKS];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Low address bits pick the bank so consecutive words spread across banks.
  if (BSEL > 0) begin : g_bsel
    assign req_bank = bus.req_addr[BS_W-1:0];
    assign req_row  = bus.req_addr[ADDR_W-1:BSEL];
  end else begin : g_nobsel
    assign req_bank = '0;
    assign req_row  = bus.req_addr;
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state       <= (INIT_ON_RST != 0) ? ST_INIT : ST_RUN;
      row_cnt     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state       <= state_next;
      row_cnt     <= (state == ST_INIT) ? row_cnt + 1'b1 : '0;
      init_done_q <= (state_next == ST_RUN);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (row_cnt == ROW_W'(BANK_WORDS - 1)) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  // A pop in this cycle frees its slot in time for a new read, which is what
  // lets a two-entry buffer sustain one read per cycle.
  assign pop         = (occ != '0) && bus.rsp_ready;
  assign push        = inflight;
  assign credit_used = occ + CNT_W'(inflight) - CNT_W'(pop);
  assign bus.req_ready = init_done_q && (state == ST_RUN) && (credit_used < CNT_W'(RSP_DEPTH));
  assign fire        = bus.req_valid && bus.req_ready;
  assign rd_fire     = fire && !bus.req_we;

  always_comb begin
    bank_csb       = '1;
    bank_web       = 1'b1;
    bank_wmask     = '0;
    bank_spare_wen = 1'b0;
    bank_addr      = req_row;
    bank_din       = bus.req_wdata;
    if (state == ST_INIT) begin
      bank_csb       = '0;
      bank_web       = 1'b0;
      bank_wmask     = '1;
      bank_spare_wen = 1'b1;
      bank_addr      = row_cnt;
      bank_din       = '0;
    end else if (fire) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_csb[b] = (req_bank != BS_W'(b));
      end
      bank_web       = !bus.req_we;
      bank_wmask     = bus.req_wmask;
      bank_spare_wen = bus.req_spare_wen;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sram_1rw_model #(
      .WORDS    (BANK_WORDS),
      .DATA_W   (DATA_W),
      .SPARE_EN (SPARE_EN)
    ) u_bank (
      .clk0       (clk0),
      .csb0       (bank_csb[b]),
      .web0       (bank_web),
      .wmask0     (bank_wmask),
      .spare_wen0 (bank_spare_wen),
      .addr0      (bank_addr),
      .din0       (bank_din),
      .dout0      (bank_dout[b])
    );
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      inflight <= 1'b0;
      rd_bank  <= '0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= rd_fire;
      rd_bank  <= req_bank;
      occ      <= occ + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk0) begin
    if (push) fifo_mem[wr_ptr] <= bank_dout[rd_bank];
  end

  assign bus.rsp_valid = (occ != '0);
  assign bus.rsp_rdata = (occ != '0) ? fifo_mem[rd_ptr] : '0;
  assign bus.init_done = init_done_q;

  overflow_chk: assert property (@(posedge clk0) disable iff (rst0)
    !(push && !pop && occ == CNT_W'(RSP_DEPTH)));
endmodule

// File: tb/tb_sram_banked_1rw_ctrl.sv
// Directed bench for sram_banked_1rw_ctrl: init timing, masked writes/reads from a
// vector table, then back-to-back, back-pressure and mid-operation reset sequences.
module tb_sram_banked_1rw_ctrl;
  localparam int ADDR_W = 12;
  localparam int MASK_W = 4;
  localparam int WORD_W = 33;
  localparam int NVEC   = 17;

  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] mask;
    bit                swen;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] exp;
  } vec_t;

  logic clk0 = 1'b0;
  logic rst0 = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  vec_t vecs [NVEC];

  sram_ctrl_if #(.ADDR_W(ADDR_W), .MASK_W(MASK_W), .WORD_W(WORD_W)) bus ();

  sram_banked_1rw_ctrl #(
    .DATA_W(32), .NUM_BANKS(4), .BANK_WORDS(1024),
    .SPARE_EN(1), .RSP_DEPTH(2), .INIT_ON_RST(1)
  ) dut (
    .clk0 (clk0),
    .rst0 (rst0),
    .bus  (bus)
  );

  always #5 clk0 = ~clk0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic doReq(input bit we, input logic [ADDR_W-1:0] addr, input logic [MASK_W-1:0] mask,
                       input bit swen, input logic [WORD_W-1:0] wdata);
    int n = 0;
    bus.req_valid     = 1'b1;
    bus.req_we        = we;
    bus.req_addr      = addr;
    bus.req_wmask     = mask;
    bus.req_spare_wen = swen;
    bus.req_wdata     = wdata;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk0);
      n++;
    end
    if (n >= 100) checkOutput("req_accept_timeout", 64'(n), 64'(0));
    @(negedge clk0);
    bus.req_valid = 1'b0;
  endtask

  task automatic getResp(output logic [WORD_W-1:0] d);
    int n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk0);
      n++;
    end
    if (n >= 50) checkOutput("rsp_timeout", 64'(n), 64'(0));
    d = bus.rsp_rdata;
    @(negedge clk0);
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    logic [WORD_W-1:0] d;
    doReq(v.we, v.addr, v.mask, v.swen, v.wdata);
    if (!v.we) begin
      getResp(d);
      checkOutput(name, 64'(d), 64'(v.exp));
    end
  endtask

  task automatic waitInit(input string name);
    int  cnt = 0;
    bit  early = 1'b0;
    while (!bus.init_done && cnt < 3000) begin
      @(negedge clk0);
      cnt++;
      if (!bus.init_done && bus.req_ready) early = 1'b1;
    end
    checkOutput({name, "_init_cycles"}, 64'(cnt), 64'(1024));
    checkOutput({name, "_ready_during_init"}, 64'(early), 64'(0));
    checkOutput({name, "_ready_after_init"}, 64'(bus.req_ready), 64'(1));
  endtask

  initial begin
    int   idx, acc, acc_first, acc_last, rsp_first, rcount;
    bit   pend;
    logic [WORD_W-1:0] d;

    vecs[0]  = '{0, 12'd100,  4'h0, 0, 33'h0,         33'h0};
    vecs[1]  = '{0, 12'd4095, 4'h0, 0, 33'h0,         33'h0};
    vecs[2]  = '{1, 12'd5,    4'h5, 0, 33'h1DEADBEEF, 33'h0};
    vecs[3]  = '{0, 12'd5,    4'h0, 0, 33'h0,         33'h000AD00EF};
    vecs[4]  = '{1, 12'd6,    4'hF, 1, 33'h112345678, 33'h0};
    vecs[5]  = '{0, 12'd6,    4'h0, 0, 33'h0,         33'h112345678};
    vecs[6]  = '{1, 12'd5,    4'h0, 0, 33'h0FFFFFFFF, 33'h0};
    vecs[7]  = '{0, 12'd5,    4'h0, 0, 33'h0,         33'h000AD00EF};
    vecs[8]  = '{1, 12'd5,    4'hA, 0, 33'h011223344, 33'h0};
    vecs[9]  = '{0, 12'd5,    4'h0, 0, 33'h0,         33'h011AD33EF};
    vecs[10] = '{1, 12'd7,    4'h0, 1, 33'h100000000, 33'h0};
    vecs[11] = '{0, 12'd7,    4'h0, 0, 33'h0,         33'h100000000};
    vecs[12] = '{1, 12'd4095, 4'hF, 0, 33'h0CAFEF00D, 33'h0};
    vecs[13] = '{0, 12'd4095, 4'h0, 0, 33'h0,         33'h0CAFEF00D};
    vecs[14] = '{0, 12'd4094, 4'h0, 0, 33'h0,         33'h0};
    vecs[15] = '{1, 12'd9,    4'hF, 0, 33'h055AA55AA, 33'h0};
    vecs[16] = '{0, 12'd9,    4'h0, 0, 33'h0,         33'h055AA55AA};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wmask = '0;
    bus.req_spare_wen = 1'b0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk0);
    checkOutput("rst_req_ready", 64'(bus.req_ready), 64'(0));
    checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    checkOutput("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    checkOutput("rst_init_done", 64'(bus.init_done), 64'(0));
    rst0 = 1'b0;
    waitInit("first");

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back reads of addresses 0..7.
    for (int i = 0; i < 8; i++) begin
      doReq(1, ADDR_W'(i), 4'hF, 1, {1'b0, 32'hC0DE0000 + 32'(i)});
    end
    idx = 0; acc_first = -1; acc_last = -1; rsp_first = -1; rcount = 0; pend = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk0);
      if (pend) idx++;
      if (bus.rsp_valid) begin
        if (rsp_first < 0) rsp_first = c;
        checkOutput($sformatf("b2b_data%0d", rcount), 64'(bus.rsp_rdata),
                    64'({1'b0, 32'hC0DE0000 + 32'(rcount)}));
        rcount++;
      end
      bus.req_valid = (idx < 8);
      bus.req_we    = 1'b0;
      bus.req_addr  = ADDR_W'(idx);
      pend = bus.req_valid && bus.req_ready;
      if (pend) begin
        if (acc_first < 0) acc_first = c;
        acc_last = c;
      end
    end
    checkOutput("b2b_count", 64'(rcount), 64'(8));
    checkOutput("b2b_latency", 64'(rsp_first - acc_first), 64'(2));
    checkOutput("b2b_sustained", 64'(acc_last - acc_first), 64'(7));

    // Back-pressure: only RSP_DEPTH reads may be taken, held data stays put.
    bus.rsp_ready = 1'b0;
    idx = 0; acc = 0; pend = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk0);
      if (pend) idx++;
      if (bus.rsp_valid) checkOutput("bp_hold_data", 64'(bus.rsp_rdata), 64'({1'b0, 32'hC0DE0000}));
      bus.req_valid = (idx < 4);
      bus.req_addr  = ADDR_W'(idx);
      pend = bus.req_valid && bus.req_ready;
      if (pend) acc++;
    end
    bus.req_valid = 1'b0;
    checkOutput("bp_accepted", 64'(acc), 64'(2));
    checkOutput("bp_req_ready", 64'(bus.req_ready), 64'(0));
    checkOutput("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    bus.rsp_ready = 1'b1;
    getResp(d);
    checkOutput("bp_rsp0", 64'(d), 64'({1'b0, 32'hC0DE0000}));
    getResp(d);
    checkOutput("bp_rsp1", 64'(d), 64'({1'b0, 32'hC0DE0001}));
    repeat (3) @(negedge clk0);
    checkOutput("bp_no_extra", 64'(bus.rsp_valid), 64'(0));

    // Reset with one response buffered and one read in flight.
    bus.rsp_ready = 1'b0;
    idx = 0; acc = 0; pend = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk0);
      if (pend) idx++;
      if (acc == 2) break;
      bus.req_valid = 1'b1;
      bus.req_addr  = ADDR_W'(3 + idx);
      pend = bus.req_ready;
      if (pend) acc++;
    end
    bus.req_valid = 1'b0;
    checkOutput("mid_pre_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    rst0 = 1'b1;
    #1;
    checkOutput("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    checkOutput("mid_rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    checkOutput("mid_rst_req_ready", 64'(bus.req_ready), 64'(0));
    checkOutput("mid_rst_init_done", 64'(bus.init_done), 64'(0));
    @(negedge clk0);
    rst0 = 1'b0;
    waitInit("second");
    checkOutput("mid_no_stale", 64'(bus.rsp_valid), 64'(0));
    bus.rsp_ready = 1'b1;
    applyStimulus('{0, 12'd3, 4'h0, 0, 33'h0, 33'h0}, "mid_reinit_read3");
    applyStimulus('{0, 12'd4095, 4'h0, 0, 33'h0, 33'h0}, "mid_reinit_read4095");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
